// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle core.
// Owns the PC, the start/done handshake, branch/call/return sequencing
// through the branch-target LUT, and a small return-address stack.
module pc_sequencer #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_AW    = 5,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_start_addr,
    input  logic              i_halt,
    input  logic              i_jump,
    input  logic              i_cond,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic [LUT_AW-1:0] i_jump_ptr,
    input  logic              i_stall,
    output logic [LUT_AW-1:0] o_lut_addr,
    input  logic [PC_W-1:0]   i_lut_target,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_running,
    output logic              o_done,
    output logic              o_fault
);

    // Stack index width and stack-pointer width (pointer must reach RAS_DEPTH).
    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned SP_W  = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_running;
    logic              r_done;
    logic              r_fault;
    logic [PC_W-1:0]   r_stack [RAS_DEPTH];

    logic [PC_W-1:0]   w_pc_inc;
    logic              w_stack_empty;
    logic              w_stack_full;
    logic              w_issue;
    logic              w_push;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;
    logic [PC_W-1:0]   w_ret_addr;

    // Sequential successor wraps naturally at 2^PC_W.
    assign w_pc_inc      = r_pc + PC_W'(1);
    assign w_stack_empty = (r_sp == '0);
    assign w_stack_full  = (r_sp == SP_W'(RAS_DEPTH));

    // An instruction is acted on only in RUN when memory is not stalling.
    assign w_issue    = (r_state == ST_RUN) && !i_stall;
    assign w_push     = w_issue && !i_halt && !i_ret && i_call && !w_stack_full;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_ret_addr = r_stack[w_pop_idx];

    // LUT pointer is a straight copy so the target returns in the same cycle.
    assign o_lut_addr = i_jump_ptr;

    assign o_pc      = r_pc;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_fault   = r_fault;

    // Return-address storage; contents are don't-care until pushed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    // Control FSM with PC, stack pointer and status outputs registered together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_sp      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pc      <= i_start_addr;
                        r_sp      <= '0;
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!i_stall) begin
                        if (i_halt) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (i_ret) begin
                            if (w_stack_empty) begin
                                r_state   <= ST_FAULT;
                                r_running <= 1'b0;
                                r_fault   <= 1'b1;
                            end else begin
                                r_pc <= w_ret_addr;
                                r_sp <= r_sp - SP_W'(1);
                            end
                        end else if (i_call) begin
                            if (w_stack_full) begin
                                r_state   <= ST_FAULT;
                                r_running <= 1'b0;
                                r_fault   <= 1'b1;
                            end else begin
                                r_pc <= i_lut_target;
                                r_sp <= r_sp + SP_W'(1);
                            end
                        end else if (i_jump && i_cond) begin
                            r_pc <= i_lut_target;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                ST_DONE: begin
                    if (i_start) begin
                        r_pc      <= i_start_addr;
                        r_sp      <= '0;
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    // Sticky until reset; PC and status hold.
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                    r_fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       halt;
    logic       jump;
    logic       cond;
    logic       call;
    logic       ret;
    logic [4:0] jump_ptr;
    logic       stall;
    logic [4:0] lut_addr;
    logic [9:0] lut_target;
    logic [9:0] pc;
    logic       running;
    logic       done;
    logic       fault;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.PC_W(10), .LUT_AW(5), .RAS_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_halt       (halt),
        .i_jump       (jump),
        .i_cond       (cond),
        .i_call       (call),
        .i_ret        (ret),
        .i_jump_ptr   (jump_ptr),
        .i_stall      (stall),
        .o_lut_addr   (lut_addr),
        .i_lut_target (lut_target),
        .o_pc         (pc),
        .o_running    (running),
        .o_done       (done),
        .o_fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int e_pc, input int e_run,
                          input int e_done, input int e_fault);
        chk({tag, ".pc"},      32'(pc),      32'(e_pc));
        chk({tag, ".running"}, 32'(running), 32'(e_run));
        chk({tag, ".done"},    32'(done),    32'(e_done));
        chk({tag, ".fault"},   32'(fault),   32'(e_fault));
    endtask

    initial begin
        int exp_ret [4];
        reset = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0; jump = 1'b0;
        cond = 1'b0; call = 1'b0; ret = 1'b0; jump_ptr = '0; stall = 1'b0;
        lut_target = '0;
        step(); step();
        chk_st("reset", 0, 0, 0, 0);

        // Launch and sequential stepping
        reset = 1'b0; start = 1'b1; start_addr = 10'd4;
        step();
        start = 1'b0;
        chk_st("start", 4, 1, 0, 0);
        for (int i = 5; i <= 10; i++) begin
            step();
            chk("seq.pc", 32'(pc), 32'(i));
        end

        // Conditional branch taken / not taken
        jump = 1'b1; cond = 1'b1; jump_ptr = 5'b10001; lut_target = 10'd64;
        #1 chk("jump.lutaddr", 32'(lut_addr), 32'd17);
        step();
        chk("jump.taken", 32'(pc), 32'd64);
        lut_target = 10'd10;
        step();
        chk("jump.back", 32'(pc), 32'd10);
        cond = 1'b0;
        step();
        chk("jump.nottaken", 32'(pc), 32'd11);
        jump = 1'b0;

        // Start while running is ignored
        start = 1'b1; start_addr = 10'd500;
        step();
        start = 1'b0;
        chk_st("run.start_ign", 12, 1, 0, 0);

        // Call / return
        jump = 1'b1; cond = 1'b1; lut_target = 10'd300;
        step();
        jump = 1'b0;
        chk("goto300", 32'(pc), 32'd300);
        call = 1'b1; jump_ptr = 5'b11100; lut_target = 10'd312;
        #1 chk("call.lutaddr", 32'(lut_addr), 32'd28);
        step();
        call = 1'b0;
        chk("call.pc", 32'(pc), 32'd312);
        step();
        chk("call.seq", 32'(pc), 32'd313);
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk("ret.pc", 32'(pc), 32'd301);
        step();
        chk("ret.seq", 32'(pc), 32'd302);

        // Stall holds a pending taken branch
        jump = 1'b1; cond = 1'b1; lut_target = 10'd20;
        step();
        chk("goto20", 32'(pc), 32'd20);
        stall = 1'b1; lut_target = 10'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("stall", 20, 1, 0, 0);
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
        chk("stall.release", 32'(pc), 32'd99);

        // Halt beats Ret in the same cycle
        call = 1'b1; lut_target = 10'd150;
        step();
        call = 1'b0;
        chk("call150", 32'(pc), 32'd150);
        halt = 1'b1; ret = 1'b1;
        step();
        halt = 1'b0; ret = 1'b0;
        chk_st("halt_ret", 150, 0, 1, 0);
        step();
        chk_st("done.hold", 150, 0, 1, 0);

        // Restart from DONE, halt, restart
        start = 1'b1; start_addr = 10'd166;
        step();
        start = 1'b0;
        chk_st("restart166", 166, 1, 0, 0);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_st("halt166", 166, 0, 1, 0);
        start = 1'b1; start_addr = 10'd177;
        step();
        start = 1'b0;
        chk_st("restart177", 177, 1, 0, 0);

        // PC wrap and wrapped return address
        jump = 1'b1; cond = 1'b1; lut_target = 10'd1023;
        step();
        jump = 1'b0;
        chk("goto1023", 32'(pc), 32'd1023);
        step();
        chk_st("wrap", 0, 1, 0, 0);
        jump = 1'b1; lut_target = 10'd1023;
        step();
        jump = 1'b0;
        call = 1'b1; lut_target = 10'd5;
        step();
        call = 1'b0;
        chk("call@1023", 32'(pc), 32'd5);
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk("ret.wrapped", 32'(pc), 32'd0);

        // Fill the stack, unwind in LIFO order
        exp_ret[0] = 1; exp_ret[1] = 201; exp_ret[2] = 211; exp_ret[3] = 221;
        for (int k = 0; k < 4; k++) begin
            call = 1'b1; lut_target = 10'(200 + 10 * k);
            step();
            chk("nest.call", 32'(pc), 32'(200 + 10 * k));
        end
        call = 1'b0; ret = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            step();
            chk("nest.ret", 32'(pc), 32'(exp_ret[k]));
        end
        ret = 1'b0;

        // Refill and overflow on the fifth call
        for (int k = 0; k < 4; k++) begin
            call = 1'b1; lut_target = 10'(200 + 10 * k);
            step();
        end
        chk_st("refill", 230, 1, 0, 0);
        lut_target = 10'd240;
        step();
        call = 1'b0;
        chk_st("overflow", 230, 0, 0, 1);
        start = 1'b1; start_addr = 10'd50;
        step();
        start = 1'b0;
        chk_st("fault.sticky", 230, 0, 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_st("fault.reset", 0, 0, 0, 0);
        step();
        chk_st("idle.hold", 0, 0, 0, 0);

        // Reset in the middle of a run
        start = 1'b1; start_addr = 10'd40;
        step();
        start = 1'b0;
        step();
        chk("run41", 32'(pc), 32'd41);
        reset = 1'b1; jump = 1'b1; cond = 1'b1; lut_target = 10'd7;
        step();
        reset = 1'b0; jump = 1'b0;
        chk_st("midrun.reset", 0, 0, 0, 0);

        // Return with empty stack
        start = 1'b1; start_addr = 10'd60;
        step();
        start = 1'b0;
        ret = 1'b1;
        step();
        ret = 1'b0;
        chk_st("underflow", 60, 0, 0, 1);
        start = 1'b1; start_addr = 10'd70;
        step();
        start = 1'b0;
        chk_st("underflow.sticky", 60, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core: owns the PC register, start/done handshake and all control-flow sequencing.
- Drives the 5-bit pointer into the branch-target lookup table and consumes the 10-bit absolute target it returns.
- Adds a small return-address stack so subroutines (e.g. increment helpers) can be called via LUT pointers and returned from.
- Sits between the instruction decoder (control strobes) and instruction ROM (PC address).

Parameters:
- PC_W, 10, PC and target width.
- LUT_AW, 5, branch-target LUT pointer width.
- RAS_DEPTH, 4, return-address stack entries (power of 2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  launch request; sampled only in IDLE/DONE.
- StartAddr  in  PC_W  first PC of program, latched with Start.
- Halt  in  1  decoder: current instruction is halt.
- Jump  in  1  decoder: current instruction is conditional branch.
- Cond  in  1  branch condition true (ALU flag).
- Call  in  1  decoder: unconditional call through LUT.
- Ret  in  1  decoder: return.
- JumpPtr  in  LUT_AW  LUT pointer field of current instruction.
- Stall  in  1  hold PC this cycle (multicycle data memory).
- LutAddr  out  LUT_AW  pointer to LUT; combinational copy of JumpPtr.
- LutTarget  in  PC_W  LUT output (combinational, same cycle).
- PC  out  PC_W  current instruction address.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- Fault  out  1  high in FAULT.

Behaviour:
- States: IDLE, RUN, DONE, FAULT. Reset (any state, any cycle, overrides all inputs) -> IDLE, PC=0, stack empty (sp=0), Running=Done=Fault=0.
- IDLE: Start=1 -> PC<=StartAddr, RUN next cycle. Start=0 -> stay; PC holds.
- RUN, Stall=1: PC, sp, stack and state hold; all decoder strobes ignored that cycle.
- RUN, Stall=0, priority Halt > Ret > Call > Jump > sequential:
  - Halt: PC holds, -> DONE.
  - Ret: sp=0 -> FAULT, PC holds; else PC<=stack[sp-1], sp<=sp-1.
  - Call: sp=RAS_DEPTH -> FAULT, PC holds; else stack[sp]<=PC+1, sp<=sp+1, PC<=LutTarget.
  - Jump&Cond: PC<=LutTarget. Jump&!Cond: PC<=PC+1.
  - Otherwise: PC<=PC+1.
- PC+1 is modulo 2^PC_W; 1023 -> 0 with no fault. Pushed return address wraps identically.
- LutTarget=0 (unmapped pointer) is a legal jump to 0; no checking.
- Start in RUN or FAULT ignored.
- DONE: Done=1 level, PC holds; Start=1 -> PC<=StartAddr, sp<=0, Done falls, RUN next cycle.
- FAULT: sticky until Reset; PC holds; Fault=1.
- Outputs registered from state: Running/Done/Fault change the cycle after the causing edge; exactly one of them high outside IDLE.
- Latency: control decision at edge N visible on PC after edge N; zero bubbles, one instruction per non-stalled cycle.

Test Plan:
- Reset, Start=1 StartAddr=4 -> PC=4, Running=1 next cycle; 3 plain cycles -> PC=5,6,7.
- PC=10, Jump=1 Cond=1 JumpPtr=5'b10001 LutTarget=64 -> LutAddr=17, PC=64; repeat with Cond=0 -> PC=11.
- PC=300, Call JumpPtr=5'b11100 LutTarget=312 -> PC=312, sp=1; Ret at 313 -> PC=301, sp=0.
- Five nested Calls with RAS_DEPTH=4 -> fifth gives Fault=1, PC holds; Ret with empty stack from fresh run -> Fault=1; Start ignored until Reset.
- Stall=1 for 3 cycles with Jump&Cond asserted at PC=20 -> PC stays 20; Stall drops -> PC=LutTarget. Halt with Ret same cycle -> DONE, sp unchanged.
- Halt at PC=166 -> Done=1, PC=166; Start StartAddr=177 -> PC=177, Running=1. Reset mid-RUN -> PC=0, IDLE. PC=1023 plain step -> PC=0.
